// File: rtl/apb_led_pkg.sv
// -----------------------------------------------------------------------------
// apb_led_pkg
// Shared constants for the APB LED output peripheral: bus widths, register
// word offsets (PADDR[11:2]) and the per-channel output mode encodings.
// -----------------------------------------------------------------------------
package apb_led_pkg;

    localparam int APB_AW = 16;
    localparam int APB_DW = 32;

    // Register word index as decoded from PADDR[11:2]
    localparam logic [9:0] OFS_DATA     = 10'd0;
    localparam logic [9:0] OFS_MODE     = 10'd1;
    localparam logic [9:0] OFS_PRESCALE = 10'd2;
    localparam logic [9:0] OFS_DUTY     = 10'd3;
    localparam logic [9:0] OFS_BLINK    = 10'd4;
    localparam logic [9:0] OFS_STATUS   = 10'd5;
    localparam logic [9:0] OFS_INTEN    = 10'd6;
    localparam logic [9:0] OFS_INTSTAT  = 10'd7;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'b00,
        MODE_PWM      = 2'b01,
        MODE_BLINK    = 2'b10,
        MODE_BLINKPWM = 2'b11
    } led_mode_e;

endpackage

// File: rtl/apb_led_if.sv
// -----------------------------------------------------------------------------
// apb_led_if
// APB3 bus bundle for the LED output peripheral.
//   slave  : PSEL, PADDR, PENABLE, PWRITE, PWDATA in; PRDATA, PREADY, PSLVERR out
//   master : the mirror image, used by the bus driver
// -----------------------------------------------------------------------------
interface apb_led_if;
    import apb_led_pkg::*;

    logic              PSEL;
    logic [APB_AW-1:0] PADDR;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/led_timebase.sv
// -----------------------------------------------------------------------------
// led_timebase
// Shared timebase for all LED channels: prescaler, PWM counter, blink counter
// and blink phase.
//   clk_i, rst_i     : clock, async active-high reset
//   clr_i            : restart all counters (register write to PRESCALE/BLINK)
//   prescale_i       : tick every prescale_i+1 clocks
//   blink_i          : number of extra PWM periods per blink half-period
//   pwm_cnt_o        : current PWM count
//   blink_phase_o    : current blink phase
//   wrap_o           : PWM counter wraps this cycle
//   toggle_o         : blink phase toggles this cycle
// -----------------------------------------------------------------------------
module led_timebase #(
    parameter int PWM_W = 8,
    parameter int PRE_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [PRE_W-1:0] prescale_i,
    input  logic [7:0]       blink_i,
    output logic [PWM_W-1:0] pwm_cnt_o,
    output logic             blink_phase_o,
    output logic             wrap_o,
    output logic             toggle_o
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             tick;

    assign tick = (pre_cnt_q == prescale_i);

    // A clear in the same cycle suppresses the strobes so that a restart
    // cannot also raise the blink interrupt.
    assign wrap_o   = tick && (pwm_cnt_q == '1) && !clr_i;
    assign toggle_o = wrap_o && (blink_cnt_q == blink_i);

    always_comb begin
        pre_cnt_d     = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d     = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wrap_o) begin
            if (toggle_o) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 8'd1;
            end
        end
        if (clr_i) begin
            pre_cnt_d     = '0;
            pwm_cnt_d     = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign pwm_cnt_o     = pwm_cnt_q;
    assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/apb_led_out.sv
// -----------------------------------------------------------------------------
// apb_led_out
// APB3 slave driving NCH LED / indicator pins. Each channel selects static
// level, PWM dimming, blink, or blinking PWM from one shared timebase.
//   PCLK, PRESET : clock, async active-high reset
//   bus          : APB3 slave port (writes in setup phase, PREADY=1, PSLVERR=0)
//   PORTOUT      : registered channel outputs
//   BLINKINT     : level interrupt, INTSTAT[0] & INTEN[0]
// Registers (word offset): DATA, MODE, PRESCALE, DUTY, BLINK, STATUS(R),
// INTEN, INTSTAT(R/W1C).
// -----------------------------------------------------------------------------
module apb_led_out
    import apb_led_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int PWM_W = 8,
    parameter int PRE_W = 16
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_led_if.slave       bus,
    output logic [NCH-1:0] PORTOUT,
    output logic           BLINKINT
);

    localparam int DUTY_W = PWM_W * NCH;

    logic [NCH-1:0]    data_q, data_d;
    logic [2*NCH-1:0]  mode_q, mode_d;
    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [7:0]        blink_q, blink_d;
    logic              inten_q, inten_d;
    logic              intstat_q, intstat_d;
    logic [NCH-1:0]    portout_q, portout_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;

    logic [9:0]        word;
    logic              wr_stb, rd_stb, tb_clr;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              blink_phase, wrap, toggle;

    assign word   = bus.PADDR[11:2];
    assign wr_stb = bus.PSEL && !bus.PENABLE && bus.PWRITE;
    assign rd_stb = bus.PSEL && !bus.PENABLE && !bus.PWRITE;
    assign tb_clr = wr_stb && ((word == OFS_PRESCALE) || (word == OFS_BLINK));

    led_timebase #(
        .PWM_W (PWM_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk_i         (PCLK),
        .rst_i         (PRESET),
        .clr_i         (tb_clr),
        .prescale_i    (prescale_q),
        .blink_i       (blink_q),
        .pwm_cnt_o     (pwm_cnt),
        .blink_phase_o (blink_phase),
        .wrap_o        (wrap),
        .toggle_o      (toggle)
    );

    // Register file next state
    always_comb begin
        data_d     = data_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        blink_d    = blink_q;
        inten_d    = inten_q;
        if (wr_stb) begin
            case (word)
                OFS_DATA:     data_d     = bus.PWDATA[NCH-1:0];
                OFS_MODE:     mode_d     = bus.PWDATA[2*NCH-1:0];
                OFS_PRESCALE: prescale_d = bus.PWDATA[PRE_W-1:0];
                OFS_DUTY:     duty_d     = bus.PWDATA[DUTY_W-1:0];
                OFS_BLINK:    blink_d    = bus.PWDATA[7:0];
                OFS_INTEN:    inten_d    = bus.PWDATA[0];
                default:      ;
            endcase
        end
        // Set from a blink toggle has priority over a same-cycle W1C
        intstat_d = intstat_q;
        if (wr_stb && (word == OFS_INTSTAT) && bus.PWDATA[0]) begin
            intstat_d = 1'b0;
        end
        if (toggle) begin
            intstat_d = 1'b1;
        end
    end

    // Per-channel output select
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PWM_W-1:0] duty_c;
        logic [1:0]       mode_c;
        logic             pwm_c;
        logic             out_c;

        assign duty_c = duty_q[c*PWM_W +: PWM_W];
        assign mode_c = mode_q[2*c +: 2];
        // Max duty is forced high so the full scale is a steady on level
        assign pwm_c  = (pwm_cnt < duty_c) || (duty_c == '1);

        always_comb begin
            out_c = 1'b0;
            case (mode_c)
                MODE_STATIC:   out_c = data_q[c];
                MODE_PWM:      out_c = pwm_c;
                MODE_BLINK:    out_c = data_q[c] & blink_phase;
                MODE_BLINKPWM: out_c = pwm_c & blink_phase;
                default:       out_c = 1'b0;
            endcase
        end

        assign portout_d[c] = out_c;
    end

    // Read data is captured in the setup phase and held for the access phase
    always_comb begin
        rdata_d = rdata_q;
        if (rd_stb) begin
            rdata_d = '0;
            case (word)
                OFS_DATA:     rdata_d[NCH-1:0]    = data_q;
                OFS_MODE:     rdata_d[2*NCH-1:0]  = mode_q;
                OFS_PRESCALE: rdata_d[PRE_W-1:0]  = prescale_q;
                OFS_DUTY:     rdata_d[DUTY_W-1:0] = duty_q;
                OFS_BLINK:    rdata_d[7:0]        = blink_q;
                OFS_STATUS:   rdata_d[NCH-1:0]    = portout_q;
                OFS_INTEN:    rdata_d[0]          = inten_q;
                OFS_INTSTAT:  rdata_d[0]          = intstat_q;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            data_q     <= '0;
            mode_q     <= '0;
            prescale_q <= '0;
            duty_q     <= '0;
            blink_q    <= '0;
            inten_q    <= 1'b0;
            intstat_q  <= 1'b0;
            portout_q  <= '0;
            rdata_q    <= '0;
        end else begin
            data_q     <= data_d;
            mode_q     <= mode_d;
            prescale_q <= prescale_d;
            duty_q     <= duty_d;
            blink_q    <= blink_d;
            inten_q    <= inten_d;
            intstat_q  <= intstat_d;
            portout_q  <= portout_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.PRDATA  = (bus.PSEL && !bus.PWRITE) ? rdata_q : '0;
    assign bus.PREADY  = 1'b1;
    assign bus.PSLVERR = 1'b0;
    assign PORTOUT     = portout_q;
    assign BLINKINT    = intstat_q & inten_q;

    // Address bits outside [11:2], write data above each field and the wrap
    // strobe are intentionally not used.
    logic unused_ok;
    assign unused_ok = ^{bus.PADDR[APB_AW-1:12], bus.PADDR[1:0], bus.PWDATA, wrap};

endmodule

// File: tb/tb_apb_led_out.sv
// -----------------------------------------------------------------------------
// tb_apb_led_out
// Directed bench for apb_led_out: register readback, PWM duty and period,
// duty limits, async reset, blink with interrupt, and timebase restart.
// -----------------------------------------------------------------------------
module tb_apb_led_out;
    import apb_led_pkg::*;

    localparam int NCH = 4;

    logic           PCLK   = 1'b0;
    logic           PRESET = 1'b1;
    logic [NCH-1:0] PORTOUT;
    logic           BLINKINT;

    int checks  = 0;
    int errors  = 0;
    int bus_bad = 0;

    apb_led_if bus();

    apb_led_out #(
        .NCH   (NCH),
        .PWM_W (8),
        .PRE_W (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .bus      (bus),
        .PORTOUT  (PORTOUT),
        .BLINKINT (BLINKINT)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b0) bus_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] addr(input logic [9:0] ofs);
        return {4'h3, ofs, 2'b00};
    endfunction

    task automatic apb_setup_write(input logic [9:0] ofs, input logic [31:0] d);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = addr(ofs); bus.PWDATA = d;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
    endtask

    task automatic apb_end();
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [9:0] ofs, input logic [31:0] d);
        apb_setup_write(ofs, d);
        apb_end();
    endtask

    task automatic apb_read(input logic [9:0] ofs, output logic [31:0] d);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = addr(ofs);
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #1 d = bus.PRDATA;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    // Sample on falling edges until PORTOUT[b] equals lvl (bounded)
    task automatic wait_level(input int b, input logic lvl, input int bound, output int n);
        n = 0;
        @(negedge PCLK);
        while (PORTOUT[b] !== lvl && n < bound) begin
            @(negedge PCLK);
            n++;
        end
    endtask

    // Called on a falling edge where PORTOUT[b] is high: length of the high
    // run followed by the low run, in clock cycles
    task automatic measure(input int b, input int bound, output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (PORTOUT[b] === 1'b1 && hi < bound) begin
            @(negedge PCLK);
            hi++;
        end
        while (PORTOUT[b] === 1'b0 && lo < bound) begin
            @(negedge PCLK);
            lo++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int hi, lo, n, cnt;

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;

        // Power-on reset
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_portout", 32'(PORTOUT), 32'h0);
        check("rst_blinkint", 32'(BLINKINT), 32'h0);
        check("rst_prdata", bus.PRDATA, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Register readback, unused bits read 0
        apb_write(OFS_DATA, 32'hFFFF_FFFA);
        apb_write(OFS_MODE, 32'hFFFF_FF00);
        apb_write(OFS_PRESCALE, 32'h1234_5678);
        apb_write(OFS_DUTY, 32'hDEAD_BEEF);
        apb_write(OFS_BLINK, 32'h0000_01A5);
        apb_write(OFS_INTEN, 32'h0000_0003);
        apb_write(OFS_INTSTAT, 32'h0000_0001);
        apb_read(OFS_DATA, rd);     check("rb_data", rd, 32'h0000_000A);
        apb_read(OFS_MODE, rd);     check("rb_mode", rd, 32'h0000_0000);
        apb_read(OFS_PRESCALE, rd); check("rb_prescale", rd, 32'h0000_5678);
        apb_read(OFS_DUTY, rd);     check("rb_duty", rd, 32'hDEAD_BEEF);
        apb_read(OFS_BLINK, rd);    check("rb_blink", rd, 32'h0000_00A5);
        apb_read(OFS_STATUS, rd);   check("rb_status", rd, 32'h0000_000A);
        apb_read(OFS_INTEN, rd);    check("rb_inten", rd, 32'h0000_0001);
        apb_read(OFS_INTSTAT, rd);  check("rb_intstat", rd, 32'h0000_0000);
        apb_read(10'd8, rd);        check("rb_unmapped", rd, 32'h0000_0000);
        check("prdata_idle", bus.PRDATA, 32'h0);
        check("static_portout", 32'(PORTOUT), 32'hA);

        // PWM: duty 0x40 on ch0, prescale 0
        apb_write(OFS_DATA, 32'h0);
        apb_write(OFS_MODE, 32'h1);
        apb_write(OFS_DUTY, 32'h40);
        apb_write(OFS_PRESCALE, 32'h0);
        wait_level(0, 1'b0, 600, n);
        wait_level(0, 1'b1, 600, n);
        for (int p = 0; p < 2; p++) begin
            measure(0, 600, hi, lo);
            check("pwm40_high", 32'(hi), 32'd64);
            check("pwm40_period", 32'(hi + lo), 32'd256);
        end

        // Duty limits
        apb_write(OFS_DUTY, 32'h00);
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge PCLK);
            if (PORTOUT[0] !== 1'b0) cnt++;
        end
        check("duty00_highs", 32'(cnt), 32'd0);
        apb_write(OFS_DUTY, 32'hFF);
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge PCLK);
            if (PORTOUT[0] !== 1'b1) cnt++;
        end
        check("dutyff_lows", 32'(cnt), 32'd0);

        // Async reset in the middle of PWM operation
        apb_write(OFS_DUTY, 32'h80);
        wait_level(0, 1'b1, 600, n);
        check("pre_reset_high", 32'(PORTOUT[0]), 32'h1);
        #2 PRESET = 1'b1;
        #1;
        check("async_rst_portout", 32'(PORTOUT), 32'h0);
        check("async_rst_blinkint", 32'(BLINKINT), 32'h0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int r = 0; r < 8; r++) begin
            apb_read(10'(r), rd);
            check($sformatf("rst_reg%0d", r), rd, 32'h0);
        end
        apb_setup_write(OFS_DATA, 32'h5);
        check("data5_at_e0", 32'(PORTOUT), 32'h0);
        apb_end();
        check("data5_at_e1", 32'(PORTOUT), 32'h5);

        // Blink with interrupt: BLINK=1 -> phase toggles every 512 cycles
        apb_write(OFS_PRESCALE, 32'h0);
        apb_write(OFS_BLINK, 32'h1);
        apb_write(OFS_MODE, 32'h08);
        apb_write(OFS_DATA, 32'h2);
        apb_write(OFS_INTEN, 32'h1);
        check("blink_int_before", 32'(BLINKINT), 32'h0);
        check("blink_out_before", 32'(PORTOUT), 32'h0);
        wait_level(1, 1'b1, 1200, n);
        check("blink_first_rise", 32'(PORTOUT[1]), 32'h1);
        check("blink_int_rise", 32'(BLINKINT), 32'h1);
        measure(1, 1200, hi, lo);
        check("blink_high", 32'(hi), 32'd512);
        check("blink_low", 32'(lo), 32'd512);
        apb_read(OFS_INTSTAT, rd);
        check("intstat_set", rd, 32'h1);
        apb_write(OFS_INTSTAT, 32'h1);
        check("w1c_blinkint", 32'(BLINKINT), 32'h0);
        apb_read(OFS_INTSTAT, rd);
        check("w1c_intstat", rd, 32'h0);

        // Restart: PRESCALE write mid-period clears the timebase
        apb_write(OFS_DATA, 32'h0);
        apb_write(OFS_MODE, 32'h1);
        apb_write(OFS_DUTY, 32'h01);
        wait_level(0, 1'b1, 600, n);
        wait_level(0, 1'b0, 600, n);
        repeat (50) @(negedge PCLK);
        apb_setup_write(OFS_PRESCALE, 32'h3);
        check("restart_at_e0", 32'(PORTOUT[0]), 32'h0);
        apb_end();
        check("restart_at_e1", 32'(PORTOUT[0]), 32'h1);
        @(negedge PCLK);
        measure(0, 1500, hi, lo);
        check("restart_cnt0_len", 32'(hi), 32'd4);
        check("restart_wrap_period", 32'(hi + lo), 32'd1024);

        check("pready_pslverr_bad", 32'(bus_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
